// File: rtl/dit_fft_8.sv
// Iterative 8-point radix-2 DIT forward FFT, one butterfly stage per clock.
// Each stage halves its results, so bins come out as DFT/8, saturated to W bits.
module dit_fft_8 #(
  parameter int W       = 9,
  parameter int TW_FRAC = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] inr0, inr1, inr2, inr3, inr4, inr5, inr6, inr7,
  input  logic signed [W-1:0] ini0, ini1, ini2, ini3, ini4, ini5, ini6, ini7,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] outreal0, outreal1, outreal2, outreal3,
  output logic signed [W-1:0] outreal4, outreal5, outreal6, outreal7,
  output logic signed [W-1:0] outimag0, outimag1, outimag2, outimag3,
  output logic signed [W-1:0] outimag4, outimag5, outimag6, outimag7
);

  localparam int PW     = 2 * W + 4;
  localparam int TW_ONE = 1 << TW_FRAC;
  localparam int TW_C45 = $rtoi(0.7071067811865476 * TW_ONE + 0.5);
  localparam logic signed [PW-1:0] SAT_HI = PW'((1 <<< (W - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = PW'(-(1 <<< (W - 1)));

  typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

  state_t              r_state;
  logic signed [W-1:0] r_re    [8];
  logic signed [W-1:0] r_im    [8];
  logic signed [W-1:0] r_outRe [8];
  logic signed [W-1:0] r_outIm [8];

  logic signed [W-1:0] w_inRe   [8];
  logic signed [W-1:0] w_inIm   [8];
  logic signed [W-1:0] w_nextRe [8];
  logic signed [W-1:0] w_nextIm [8];
  logic [2:0]          w_idxA;
  logic [2:0]          w_idxB;
  logic [1:0]          w_tw;
  logic [4*W-1:0]      w_bfly;

  assign w_inRe = '{inr0, inr1, inr2, inr3, inr4, inr5, inr6, inr7};
  assign w_inIm = '{ini0, ini1, ini2, ini3, ini4, ini5, ini6, ini7};

  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  // Returns {topRe, topIm, botRe, botIm}; W8^0 skips the multiplier so it is exact.
  function automatic logic [4*W-1:0] butterfly(
    input logic signed [W-1:0] aRe, aIm, bRe, bIm,
    input logic [1:0]          tw
  );
    logic signed [PW-1:0] wRe, wIm, pRe, pIm, topRe, topIm, botRe, botIm;
    case (tw)
      2'd0:    begin wRe = PW'(TW_ONE);  wIm = '0;              end
      2'd1:    begin wRe = PW'(TW_C45);  wIm = PW'(-TW_C45);    end
      2'd2:    begin wRe = '0;           wIm = PW'(-TW_ONE);    end
      default: begin wRe = PW'(-TW_C45); wIm = PW'(-TW_C45);    end
    endcase
    if (tw == 2'd0) begin
      pRe = PW'(bRe);
      pIm = PW'(bIm);
    end else begin
      pRe = (PW'(bRe) * wRe - PW'(bIm) * wIm) >>> TW_FRAC;
      pIm = (PW'(bRe) * wIm + PW'(bIm) * wRe) >>> TW_FRAC;
    end
    topRe = (PW'(aRe) + pRe) >>> 1;
    topIm = (PW'(aIm) + pIm) >>> 1;
    botRe = (PW'(aRe) - pRe) >>> 1;
    botIm = (PW'(aIm) - pIm) >>> 1;
    return {sat(topRe), sat(topIm), sat(botRe), sat(botIm)};
  endfunction

  // The four butterflies of the current stage; pairing and twiddles follow the span.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_nextRe[k] = r_re[k];
      w_nextIm[k] = r_im[k];
    end
    w_idxA = '0;
    w_idxB = '0;
    w_tw   = '0;
    w_bfly = '0;
    for (int j = 0; j < 4; j++) begin
      case (r_state)
        S1: begin
          w_idxA = 3'(2 * j);
          w_idxB = 3'(2 * j + 1);
          w_tw   = 2'd0;
        end
        S2: begin
          w_idxA = 3'((j / 2) * 4 + (j % 2));
          w_idxB = 3'((j / 2) * 4 + (j % 2) + 2);
          w_tw   = 2'((j % 2) * 2);
        end
        default: begin
          w_idxA = 3'(j);
          w_idxB = 3'(j + 4);
          w_tw   = 2'(j);
        end
      endcase
      w_bfly = butterfly(r_re[w_idxA], r_im[w_idxA], r_re[w_idxB], r_im[w_idxB], w_tw);
      w_nextRe[w_idxA] = w_bfly[4*W-1 -: W];
      w_nextIm[w_idxA] = w_bfly[3*W-1 -: W];
      w_nextRe[w_idxB] = w_bfly[2*W-1 -: W];
      w_nextIm[w_idxB] = w_bfly[W-1 -: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        r_re[k]    <= '0;
        r_im[k]    <= '0;
        r_outRe[k] <= '0;
        r_outIm[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int k = 0; k < 8; k++) begin
              r_re[k] <= w_inRe[{k[0], k[1], k[2]}];
              r_im[k] <= w_inIm[{k[0], k[1], k[2]}];
            end
            in_ready <= 1'b0;
            r_state  <= S1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S1, S2: begin
          r_re    <= w_nextRe;
          r_im    <= w_nextIm;
          r_state <= (r_state == S1) ? S2 : S3;
        end
        S3: begin
          r_outRe   <= w_nextRe;
          r_outIm   <= w_nextIm;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign outreal0 = r_outRe[0];
  assign outreal1 = r_outRe[1];
  assign outreal2 = r_outRe[2];
  assign outreal3 = r_outRe[3];
  assign outreal4 = r_outRe[4];
  assign outreal5 = r_outRe[5];
  assign outreal6 = r_outRe[6];
  assign outreal7 = r_outRe[7];
  assign outimag0 = r_outIm[0];
  assign outimag1 = r_outIm[1];
  assign outimag2 = r_outIm[2];
  assign outimag3 = r_outIm[3];
  assign outimag4 = r_outIm[4];
  assign outimag5 = r_outIm[5];
  assign outimag6 = r_outIm[6];
  assign outimag7 = r_outIm[7];

endmodule

// File: tb/tb_dit_fft_8.sv
// Testbench for dit_fft_8: directed frames plus $urandom frames against a
// generic radix-2 reference and a floating-point DFT.
module tb_dit_fft_8;

  localparam int W = 9;

  logic clk = 1'b0;
  logic rst;
  logic inValid;
  logic inReady;
  logic outValid;
  logic outReady;
  logic signed [W-1:0] dRe [8];
  logic signed [W-1:0] dIm [8];
  logic signed [W-1:0] qRe [8];
  logic signed [W-1:0] qIm [8];
  logic signed [W-1:0] or0, or1, or2, or3, or4, or5, or6, or7;
  logic signed [W-1:0] oi0, oi1, oi2, oi3, oi4, oi5, oi6, oi7;

  int checks = 0;
  int errors = 0;
  int xr [8];
  int xi [8];
  int er [8];
  int ei [8];

  always #5 clk = ~clk;

  dit_fft_8 #(.W(W), .TW_FRAC(7)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .inr0(dRe[0]), .inr1(dRe[1]), .inr2(dRe[2]), .inr3(dRe[3]),
    .inr4(dRe[4]), .inr5(dRe[5]), .inr6(dRe[6]), .inr7(dRe[7]),
    .ini0(dIm[0]), .ini1(dIm[1]), .ini2(dIm[2]), .ini3(dIm[3]),
    .ini4(dIm[4]), .ini5(dIm[5]), .ini6(dIm[6]), .ini7(dIm[7]),
    .out_valid(outValid), .out_ready(outReady),
    .outreal0(or0), .outreal1(or1), .outreal2(or2), .outreal3(or3),
    .outreal4(or4), .outreal5(or5), .outreal6(or6), .outreal7(or7),
    .outimag0(oi0), .outimag1(oi1), .outimag2(oi2), .outimag3(oi3),
    .outimag4(oi4), .outimag5(oi5), .outimag6(oi6), .outimag7(oi7)
  );

  assign qRe = '{or0, or1, or2, or3, or4, or5, or6, or7};
  assign qIm = '{oi0, oi1, oi2, oi3, oi4, oi5, oi6, oi7};

  function automatic int satW(input int v);
    if (v > (1 << (W - 1)) - 1) return (1 << (W - 1)) - 1;
    if (v < -(1 << (W - 1)))    return -(1 << (W - 1));
    return v;
  endfunction

  // Textbook iterative radix-2 DIT over arbitrary span, halving and saturating each stage.
  task automatic model_fft();
    int ar [8];
    int ai [8];
    int twr [4];
    int twi [4];
    twr = '{128, 91, 0, -91};
    twi = '{0, -91, -128, -91};
    for (int k = 0; k < 8; k++) begin
      int rev;
      rev = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      ar[k] = xr[rev];
      ai[k] = xi[rev];
    end
    for (int span = 1; span < 8; span = span * 2) begin
      for (int g = 0; g < 8; g = g + 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int t, a, b, pr, pi, tr, ti;
          t  = j * (4 / span);
          a  = g + j;
          b  = a + span;
          pr = (ar[b] * twr[t] - ai[b] * twi[t]) >>> 7;
          pi = (ar[b] * twi[t] + ai[b] * twr[t]) >>> 7;
          tr = satW((ar[a] + pr) >>> 1);
          ti = satW((ai[a] + pi) >>> 1);
          ar[b] = satW((ar[a] - pr) >>> 1);
          ai[b] = satW((ai[a] - pi) >>> 1);
          ar[a] = tr;
          ai[a] = ti;
        end
      end
    end
    er = ar;
    ei = ai;
  endtask

  // Presents xr/xi, waits for acceptance, then waits for out_valid; returns at a negedge.
  task automatic run_frame(output int lat, output bit got);
    int n;
    for (int k = 0; k < 8; k++) begin
      dRe[k] = W'(xr[k]);
      dIm[k] = W'(xi[k]);
    end
    got = 1'b0;
    lat = 0;
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) begin
      inValid = 1'b0;
      return;
    end
    @(negedge clk);
    inValid = 1'b0;
    while (!outValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = outValid;
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 8; k++) begin
      xr[k] = 0;
      xi[k] = 0;
    end
  endtask

  task automatic test_reset();
    int nz;
    rst = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      inValid = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        dRe[k] = W'($urandom);
        dIm[k] = W'($urandom);
      end
      @(negedge clk);
      checks++;
      if (outValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_out_valid got %b exp 0", outValid);
      end
      checks++;
      if (inReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_in_ready got %b exp 0", inReady);
      end
      nz = 0;
      for (int k = 0; k < 8; k++) if (qRe[k] !== 0 || qIm[k] !== 0) nz++;
      checks++;
      if (nz != 0) begin
        errors++;
        $display("[TB] FAIL reset_outputs nonzero bins got %0d exp 0", nz);
      end
    end
    rst = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_in_ready got %b exp 1", inReady);
    end
  endtask

  task automatic test_impulse();
    int lat;
    bit got;
    clear_frame();
    xr[0] = 64;
    run_frame(lat, got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL impulse_out_valid got 0 exp 1");
    end
    checks++;
    if (lat < 3 || lat > 4) begin
      errors++;
      $display("[TB] FAIL impulse_latency got %0d exp 3..4", lat);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (qRe[k] !== 9'sd8 || qIm[k] !== 9'sd0) begin
        errors++;
        $display("[TB] FAIL impulse bin%0d got (%0d,%0d) exp (8,0)", k, qRe[k], qIm[k]);
      end
    end
  endtask

  task automatic test_dc();
    int lat;
    bit got;
    clear_frame();
    for (int k = 0; k < 8; k++) xr[k] = 64;
    run_frame(lat, got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL dc_out_valid got 0 exp 1");
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (qRe[k] !== W'((k == 0) ? 64 : 0) || qIm[k] !== 9'sd0) begin
        errors++;
        $display("[TB] FAIL dc bin%0d got (%0d,%0d) exp (%0d,0)", k, qRe[k], qIm[k], (k == 0) ? 64 : 0);
      end
    end
  endtask

  task automatic test_nyquist();
    int lat;
    bit got;
    clear_frame();
    for (int k = 0; k < 8; k++) xr[k] = (k % 2 == 0) ? 64 : -64;
    run_frame(lat, got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL nyquist_out_valid got 0 exp 1");
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (qRe[k] !== W'((k == 4) ? 64 : 0) || qIm[k] !== 9'sd0) begin
        errors++;
        $display("[TB] FAIL nyquist bin%0d got (%0d,%0d) exp (%0d,0)", k, qRe[k], qIm[k], (k == 4) ? 64 : 0);
      end
    end
  endtask

  task automatic test_tone();
    int lat;
    bit got;
    clear_frame();
    xr[1] = 64;
    model_fft();
    run_frame(lat, got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL tone_out_valid got 0 exp 1");
    end
    checks++;
    if (qRe[1] < 5 || qRe[1] > 6 || qIm[1] < -6 || qIm[1] > -5) begin
      errors++;
      $display("[TB] FAIL tone_bin1 got (%0d,%0d) exp (5..6,-6..-5)", qRe[1], qIm[1]);
    end
    checks++;
    if (qRe[2] !== 9'sd0 || qIm[2] !== -9'sd8) begin
      errors++;
      $display("[TB] FAIL tone_bin2 got (%0d,%0d) exp (0,-8)", qRe[2], qIm[2]);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (qRe[k] !== W'(er[k]) || qIm[k] !== W'(ei[k])) begin
        errors++;
        $display("[TB] FAIL tone_model bin%0d got (%0d,%0d) exp (%0d,%0d)", k, qRe[k], qIm[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    bit got;
    for (int f = 0; f < 7; f++) begin
      for (int k = 0; k < 8; k++) begin
        if (f == 0) begin
          xr[k] = 255;
          xi[k] = 255;
        end else begin
          case ($urandom_range(0, 2))
            0:       xr[k] = 255;
            1:       xr[k] = -256;
            default: xr[k] = int'($urandom_range(0, 511)) - 256;
          endcase
          case ($urandom_range(0, 2))
            0:       xi[k] = 255;
            1:       xi[k] = -256;
            default: xi[k] = int'($urandom_range(0, 511)) - 256;
          endcase
        end
      end
      model_fft();
      run_frame(lat, got);
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL sat_out_valid frame%0d got 0 exp 1", f);
      end
      if (f == 0) begin
        checks++;
        if (qRe[0] !== 9'sd255 || qIm[0] !== 9'sd255) begin
          errors++;
          $display("[TB] FAIL sat_max_bin0 got (%0d,%0d) exp (255,255)", qRe[0], qIm[0]);
        end
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (qRe[k] !== W'(er[k]) || qIm[k] !== W'(ei[k])) begin
          errors++;
          $display("[TB] FAIL sat frame%0d bin%0d got (%0d,%0d) exp (%0d,%0d)", f, k, qRe[k], qIm[k], er[k], ei[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat, bad;
    bit got;
    real sr, si, ang;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 8; k++) begin
        xr[k] = int'($urandom_range(0, 120)) - 60;
        xi[k] = int'($urandom_range(0, 120)) - 60;
      end
      model_fft();
      run_frame(lat, got);
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL random_out_valid frame%0d got 0 exp 1", f);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (qRe[k] !== W'(er[k]) || qIm[k] !== W'(ei[k])) begin
          errors++;
          $display("[TB] FAIL random frame%0d bin%0d got (%0d,%0d) exp (%0d,%0d)", f, k, qRe[k], qIm[k], er[k], ei[k]);
        end
      end
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < 8; n++) begin
          ang = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
          sr = sr + real'(xr[n]) * $cos(ang) + real'(xi[n]) * $sin(ang);
          si = si + real'(xi[n]) * $cos(ang) - real'(xr[n]) * $sin(ang);
        end
        sr = sr / 8.0;
        si = si / 8.0;
        if (real'(qRe[k]) - sr > 2.0 || sr - real'(qRe[k]) > 2.0 ||
            real'(qIm[k]) - si > 2.0 || si - real'(qIm[k]) > 2.0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL random_dft frame%0d bins off by >2 LSB got %0d exp 0", f, bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int n, bad, period;
    for (int k = 0; k < 8; k++) begin
      xr[k] = int'($urandom_range(0, 200)) - 100;
      xi[k] = int'($urandom_range(0, 200)) - 100;
      dRe[k] = W'(xr[k]);
      dIm[k] = W'(xi[k]);
    end
    model_fft();
    outReady = 1'b1;
    inValid = 1'b0;
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    inValid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (inValid && inReady) acc.push_back(c);
      if (outValid) begin
        bad = 0;
        for (int k = 0; k < 8; k++)
          if (qRe[k] !== W'(er[k]) || qIm[k] !== W'(ei[k])) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("[TB] FAIL b2b_bins cycle%0d wrong bins got %0d exp 0", c, bad);
        end
      end
      @(negedge clk);
    end
    inValid = 1'b0;
    period = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
    checks++;
    if (period != 5) begin
      errors++;
      $display("[TB] FAIL b2b_period got %0d exp 5", period);
    end
    checks++;
    if (acc.size() < 5) begin
      errors++;
      $display("[TB] FAIL b2b_frames accepted got %0d exp >=5", acc.size());
    end
  endtask

  task automatic test_backpressure();
    int lat, bad;
    bit got;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    for (int k = 0; k < 8; k++) begin
      xr[k] = int'($urandom_range(0, 200)) - 100;
      xi[k] = int'($urandom_range(0, 200)) - 100;
    end
    model_fft();
    run_frame(lat, got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL bp_out_valid got 0 exp 1");
    end
    inValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bad = 0;
      for (int k = 0; k < 8; k++)
        if (qRe[k] !== W'(er[k]) || qIm[k] !== W'(ei[k])) bad++;
      checks++;
      if (outValid !== 1'b1 || inReady !== 1'b0 || bad != 0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle%0d got valid=%b ready=%b badbins=%0d exp valid=1 ready=0 badbins=0",
                 c, outValid, inReady, bad);
      end
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", outValid, inReady);
    end
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (qRe[k] !== W'(er[k]) || qIm[k] !== W'(ei[k])) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL bp_outputs_after_idle wrong bins got %0d exp 0", bad);
    end
  endtask

  task automatic test_reset_midframe();
    int n, nz, lat;
    bit got;
    for (int k = 0; k < 8; k++) begin
      xr[k] = int'($urandom_range(0, 200)) - 100;
      xi[k] = int'($urandom_range(0, 200)) - 100;
      dRe[k] = W'(xr[k]);
      dIm[k] = W'(xi[k]);
    end
    outReady = 1'b1;
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nz = 0;
    for (int k = 0; k < 8; k++) if (qRe[k] !== 0 || qIm[k] !== 0) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs nonzero bins got %0d exp 0", nz);
    end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (outValid !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("[TB] FAIL midreset_out_valid cycles high got %0d exp 0", n);
    end
    model_fft();
    run_frame(lat, got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL midreset_recover_valid got 0 exp 1");
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (qRe[k] !== W'(er[k]) || qIm[k] !== W'(ei[k])) begin
        errors++;
        $display("[TB] FAIL midreset_recover bin%0d got (%0d,%0d) exp (%0d,%0d)", k, qRe[k], qIm[k], er[k], ei[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dRe[k] = '0;
      dIm[k] = '0;
    end
    test_reset();
    test_impulse();
    test_dc();
    test_nyquist();
    test_tone();
    test_saturation();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
